// File: rtl/board_pkg.sv
// Shared types for the board reader: board geometry, coordinate type, reader FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package board_pkg;

    // Board rows and columns; the reader is built and checked at 8.
    localparam int BOARD_DIM = 8;

    // Row or column index on the 8x8 board.
    typedef logic [2:0] coord_t;

    // Reader control states.
    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_SCAN = 2'd1,
        RD_EMIT = 2'd2,
        RD_DONE = 2'd3
    } rd_state_e;

endpackage

// File: rtl/board_reader.sv
// Snapshots the live board on start, walks it row-major and presents each filled cell's coordinate.
// Latency: one cycle per empty cell, two per filled cell (scan + emit), then a one-cycle done pulse.
// Backpressure: cell_valid/cell_ready handshake; cell_ready low holds the presented coordinate indefinitely.
//
// Ports: clk, rst_n (async active-low); board (live board, board[r][c]=1 filled); start (sampled in IDLE);
//        busy (scan in progress); cell_valid/cell_ready/row_out/clm_out (filled-cell stream);
//        done (end-of-scan pulse); fill_count, row_full (results of last scan, held until next start).
module board_reader #(
    parameter int BOARD_DIM = board_pkg::BOARD_DIM
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BOARD_DIM-1:0] board [BOARD_DIM-1:0],
    input  logic                 start,
    output logic                 busy,
    output logic                 cell_valid,
    input  logic                 cell_ready,
    output logic [2:0]           row_out,
    output logic [2:0]           clm_out,
    output logic                 done,
    output logic [6:0]           fill_count,
    output logic [BOARD_DIM-1:0] row_full
);

    import board_pkg::*;

    localparam int NCELLS = BOARD_DIM * BOARD_DIM;

    // Index and counter widths are sized for the 8x8 board: idx[5:3]=row, idx[2:0]=column.
    localparam logic [5:0] LAST_IDX = 6'd63;

    rd_state_e              state_q, state_d;
    logic [NCELLS-1:0]      snap_q, snap_d;
    logic [5:0]             idx_q, idx_d;
    logic [6:0]             fill_q, fill_d;
    logic [BOARD_DIM-1:0]   row_full_q, row_full_d;
    coord_t                 row_q, row_d;
    coord_t                 clm_q, clm_d;

    logic [NCELLS-1:0]      board_flat;
    logic [BOARD_DIM-1:0]   snap_row_full;

    // Flatten the live board so that bit r*BOARD_DIM+c matches the scan index of cell (r,c).
    always_comb begin
        board_flat = '0;
        for (int r = 0; r < BOARD_DIM; r++) begin
            for (int c = 0; c < BOARD_DIM; c++) begin
                board_flat[r*BOARD_DIM + c] = board[r][c];
            end
        end
    end

    always_comb begin
        snap_row_full = '0;
        for (int r = 0; r < BOARD_DIM; r++) begin
            snap_row_full[r] = &snap_q[r*BOARD_DIM +: BOARD_DIM];
        end
    end

    always_comb begin
        state_d    = state_q;
        snap_d     = snap_q;
        idx_d      = idx_q;
        fill_d     = fill_q;
        row_full_d = row_full_q;
        row_d      = row_q;
        clm_d      = clm_q;

        case (state_q)
            RD_IDLE: begin
                if (start) begin
                    snap_d     = board_flat;
                    fill_d     = '0;
                    row_full_d = '0;
                    idx_d      = '0;
                    state_d    = RD_SCAN;
                end
            end

            RD_SCAN: begin
                if (snap_q[idx_q]) begin
                    fill_d  = fill_q + 7'd1;
                    row_d   = idx_q[5:3];
                    clm_d   = idx_q[2:0];
                    state_d = RD_EMIT;
                end else if (idx_q == LAST_IDX) begin
                    row_full_d = snap_row_full;
                    state_d    = RD_DONE;
                end else begin
                    idx_d = idx_q + 6'd1;
                end
            end

            RD_EMIT: begin
                if (cell_ready) begin
                    if (idx_q == LAST_IDX) begin
                        // Last cell accepted: idx stays at 63 rather than wrapping.
                        row_full_d = snap_row_full;
                        state_d    = RD_DONE;
                    end else begin
                        idx_d   = idx_q + 6'd1;
                        state_d = RD_SCAN;
                    end
                end
            end

            RD_DONE: begin
                state_d = RD_IDLE;
            end

            default: begin
                state_d = RD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RD_IDLE;
            snap_q     <= '0;
            idx_q      <= '0;
            fill_q     <= '0;
            row_full_q <= '0;
            row_q      <= '0;
            clm_q      <= '0;
        end else begin
            state_q    <= state_d;
            snap_q     <= snap_d;
            idx_q      <= idx_d;
            fill_q     <= fill_d;
            row_full_q <= row_full_d;
            row_q      <= row_d;
            clm_q      <= clm_d;
        end
    end

    assign busy       = (state_q == RD_SCAN) || (state_q == RD_EMIT);
    assign cell_valid = (state_q == RD_EMIT);
    assign done       = (state_q == RD_DONE);
    assign row_out    = row_q;
    assign clm_out    = clm_q;
    assign fill_count = fill_q;
    assign row_full   = row_full_q;

endmodule

// File: tb/tb_board_reader.sv
// Testbench for board_reader: directed board patterns against a queue-based reference of the scan.
// Latency: n/a.
// Backpressure: drives cell_ready directly, including multi-cycle stalls.
module tb_board_reader;

    logic       clk;
    logic       rst_n;
    logic [7:0] board [7:0];
    logic       start;
    logic       busy;
    logic       cell_valid;
    logic       cell_ready;
    logic [2:0] row_out;
    logic [2:0] clm_out;
    logic       done;
    logic [6:0] fill_count;
    logic [7:0] row_full;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    board_reader #(.BOARD_DIM(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .board      (board),
        .start      (start),
        .busy       (busy),
        .cell_valid (cell_valid),
        .cell_ready (cell_ready),
        .row_out    (row_out),
        .clm_out    (clm_out),
        .done       (done),
        .fill_count (fill_count),
        .row_full   (row_full)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // A scan started in cycle s with n filled cells and k stalled emit cycles ends with
    // done in cycle s+65+n+k; filled cells appear in ascending row-major index order.
    logic        m_active = 1'b0;
    int          m_start  = 0;
    int          m_n      = 0;
    int          m_stalls = 0;
    logic [6:0]  m_fill   = '0;
    logic [7:0]  m_rf     = '0;
    logic [5:0]  exp_q[$];
    logic [5:0]  acc_log[$];
    int          done_seen = 0;

    task automatic model_capture();
        logic [63:0] snap;
        int          cnt;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                snap[r*8 + c] = board[r][c];
        exp_q.delete();
        m_n  = 0;
        m_rf = '0;
        for (int i = 0; i < 64; i++) begin
            if (snap[i]) begin
                exp_q.push_back(6'(i));
                m_n++;
            end
        end
        for (int r = 0; r < 8; r++) begin
            cnt = 0;
            for (int c = 0; c < 8; c++) if (snap[r*8 + c]) cnt++;
            m_rf[r] = (cnt == 8);
        end
        m_start  = cyc;
        m_stalls = 0;
        m_active = 1'b1;
    endtask

    // Compare process: inputs change just after posedge, so at negedge both inputs and
    // outputs describe the current cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (done) done_seen++;
            if (!rst_n) begin
                chk("rst_busy",     busy, 0);
                chk("rst_valid",    cell_valid, 0);
                chk("rst_done",     done, 0);
                chk("rst_coord",    {row_out, clm_out}, 0);
                chk("rst_fill",     fill_count, 0);
                chk("rst_rowfull",  row_full, 0);
                m_active = 1'b0;
                m_fill   = '0;
                m_rf     = '0;
                exp_q.delete();
            end else if (m_active) begin
                if (cyc - m_start == 65 + m_n + m_stalls) begin
                    chk("done_pulse",   done, 1);
                    chk("done_busy",    busy, 0);
                    chk("done_valid",   cell_valid, 0);
                    chk("done_fill",    fill_count, 64'(m_n));
                    chk("done_rowfull", row_full, m_rf);
                    chk("done_pending", exp_q.size(), 0);
                    m_fill   = 7'(m_n);
                    m_active = 1'b0;
                end else begin
                    chk("scan_busy", busy, 1);
                    chk("scan_done", done, 0);
                    if (cell_valid) begin
                        chk("emit_expected", exp_q.size() != 0, 1);
                        if (exp_q.size() != 0) begin
                            chk("emit_coord", {row_out, clm_out}, exp_q[0]);
                            if (cell_ready) begin
                                acc_log.push_back({row_out, clm_out});
                                void'(exp_q.pop_front());
                            end else begin
                                m_stalls++;
                            end
                        end
                    end
                end
            end else begin
                chk("idle_busy",    busy, 0);
                chk("idle_valid",   cell_valid, 0);
                chk("idle_done",    done, 0);
                chk("idle_fill",    fill_count, m_fill);
                chk("idle_rowfull", row_full, m_rf);
                if (start) model_capture();
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_board(input logic [63:0] bits);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                board[r][c] = bits[r*8 + c];
    endtask

    task automatic do_start(output int c0);
        tick();
        start = 1'b1;
        c0    = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int dc);
        dc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                dc = cyc;
                break;
            end
        end
        chk("done_reached", done, 1);
    endtask

    task automatic wait_valid(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (cell_valid) break;
        end
        chk("valid_reached", cell_valid, 1);
    endtask

    // ---------------- directed tests ----------------
    int c0, d1, d2, ds0;

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        cell_ready = 1'b1;
        set_board(64'h0);

        // Reset state.
        repeat (2) @(negedge clk);
        chk("reset_busy",    busy, 0);
        chk("reset_valid",   cell_valid, 0);
        chk("reset_done",    done, 0);
        chk("reset_fill",    fill_count, 0);
        chk("reset_rowfull", row_full, 0);
        tick();
        rst_n = 1'b1;

        // Empty board: 64 scan cycles, done at +65, nothing emitted.
        acc_log.delete();
        do_start(c0);
        wait_done(200, d1);
        chk("empty_latency", d1 - c0, 65);
        chk("empty_fill",    fill_count, 0);
        chk("empty_rowfull", row_full, 0);
        chk("empty_emits",   acc_log.size(), 0);

        // Corners plus (3,5): done at +68, emitted in row-major order.
        tick();
        acc_log.delete();
        set_board(64'h8000_0000_2000_0001);
        cell_ready = 1'b1;
        do_start(c0);
        wait_done(300, d1);
        chk("three_latency", d1 - c0, 68);
        chk("three_fill",    fill_count, 3);
        chk("three_emits",   acc_log.size(), 3);
        if (acc_log.size() == 3) begin
            chk("three_first",  acc_log[0], 6'd0);
            chk("three_second", acc_log[1], 6'd29);
            chk("three_third",  acc_log[2], 6'd63);
        end

        // Row 2 full with a 5-cycle stall on the first emit.
        tick();
        acc_log.delete();
        set_board(64'h0000_0000_00FF_0000);
        cell_ready = 1'b0;
        do_start(c0);
        wait_valid(100);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", cell_valid, 1);
            chk("stall_row",   row_out, 3'd2);
            chk("stall_clm",   clm_out, 3'd0);
            if (i < 4) @(negedge clk);
        end
        tick();
        cell_ready = 1'b1;
        wait_done(300, d1);
        chk("row2_latency", d1 - c0, 78);
        chk("row2_rowfull", row_full, 8'h04);
        chk("row2_fill",    fill_count, 8);
        chk("row2_emits",   acc_log.size(), 8);
        if (acc_log.size() == 8) begin
            chk("row2_first", acc_log[0], 6'd16);
            chk("row2_last",  acc_log[7], 6'd23);
        end

        // Board cleared one cycle after start: the snapshot is still scanned.
        tick();
        acc_log.delete();
        set_board((64'd1 << 9) | (64'd1 << 38) | (64'd1 << 48) | (64'd1 << 59));
        do_start(c0);
        set_board(64'h0);
        wait_done(300, d1);
        chk("snap_latency", d1 - c0, 69);
        chk("snap_fill",    fill_count, 4);
        chk("snap_emits",   acc_log.size(), 4);
        if (acc_log.size() == 4) begin
            chk("snap_e0", acc_log[0], 6'd9);
            chk("snap_e1", acc_log[1], 6'd38);
            chk("snap_e2", acc_log[2], 6'd48);
            chk("snap_e3", acc_log[3], 6'd59);
        end

        // Reset while (3,5) is being presented: outputs drop at once, no done.
        tick();
        acc_log.delete();
        set_board((64'd1 << 29) | (64'd1 << 63));
        cell_ready = 1'b0;
        do_start(c0);
        wait_valid(100);
        chk("abort_row", row_out, 3'd3);
        chk("abort_clm", clm_out, 3'd5);
        ds0 = done_seen;
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy",  busy, 0);
        chk("abort_valid", cell_valid, 0);
        chk("abort_done",  done, 0);
        chk("abort_coord", {row_out, clm_out}, 0);
        chk("abort_fill",  fill_count, 0);
        tick();
        tick();
        rst_n = 1'b1;
        set_board(64'h0);
        cell_ready = 1'b1;
        do_start(c0);
        wait_done(200, d1);
        chk("abort_rescan_latency", d1 - c0, 65);
        chk("abort_rescan_fill",    fill_count, 0);
        chk("abort_one_done",       done_seen - ds0, 1);

        // Start held through the scan: one scan only, unless still high in IDLE.
        tick();
        set_board(64'd1 << 42);
        cell_ready = 1'b1;
        tick();
        start = 1'b1;
        c0    = cyc;
        ds0   = done_seen;
        wait_done(200, d1);
        chk("hold_latency", d1 - c0, 66);
        tick();
        start = 1'b0;
        repeat (100) @(negedge clk);
        chk("hold_single_done", done_seen - ds0, 1);
        chk("hold_idle_busy",   busy, 0);

        tick();
        start = 1'b1;
        c0    = cyc;
        wait_done(200, d1);
        chk("rehold_latency", d1 - c0, 66);
        tick();
        tick();
        start = 1'b0;
        wait_done(200, d2);
        chk("rehold_second_scan", d2 - d1, 67);
        chk("rehold_fill",        fill_count, 1);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
